// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encodings,
// frame geometry and the bit-period calculation used by the transmitter too.
package uart_rx_pkg;

    typedef logic [7:0] uart_byte_t;

    localparam int DATA_BITS = 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    // Number of system clocks that make up one bit on the line.
    function automatic int calc_clks_per_bit(input int clk_mhz, input int baud);
        return (clk_mhz * 1000000) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous receive FIFO. Pointers carry one extra wrap bit so that
// full and empty can be told apart. A pop frees a slot in the same cycle, so a
// push alongside a pop is accepted even when the FIFO is full.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push,
    input  uart_byte_t push_data,
    input  logic       pop,
    output uart_byte_t pop_data,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);

    uart_byte_t    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Occupancy flags and the effective push/pop decisions for this cycle.
    always_comb begin
        empty    = (wr_ptr == rd_ptr);
        full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
    end

    // Pointer advance; contents are untouched when a push is refused.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage write; the array needs no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, idle-high line, with a small receive FIFO
// and sticky framing / overflow / parity error flags.
// Optional feature: define UART_RX_PARITY_EN to receive 8E1 frames and drive
// par_err; without it the parity state is absent and par_err is tied low.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_MHZ    = 12,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       ovf_err,
    output logic       par_err,
    input  logic       err_clr
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_MHZ, BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta;
    logic             rxs;
    logic [2:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    uart_byte_t       shift_reg;
    logic             tick;
    logic             push;
    logic             frame_set;
    logic             ovf_set;
    logic             fifo_empty;
    logic             fifo_full;
`ifdef UART_RX_PARITY_EN
    logic             par_bad;
    logic             par_set;
`endif

    // Two-flop synchroniser; resets to the idle level so no false start.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Sample strobe, completed-byte push and error set conditions.
    always_comb begin
        tick      = (baud_cnt == '0);
        frame_set = (state == ST_STOP) && tick && !rxs;
`ifdef UART_RX_PARITY_EN
        push      = (state == ST_STOP) && tick && rxs && !par_bad;
        par_set   = (state == ST_PARITY) && tick && (rxs != ^shift_reg);
`else
        push      = (state == ST_STOP) && tick && rxs;
`endif
        ovf_set   = push && fifo_full && !(rx_ready && !fifo_empty);
    end

    // Receive FSM: start validation at mid-bit, then one sample per bit period.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rxs) begin
                        state    <= ST_START;
                        bit_cnt  <= '0;
                        baud_cnt <= HALF_LOAD;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (rxs) begin
                            state <= ST_IDLE;
                        end else begin
                            state    <= ST_DATA;
                            baud_cnt <= FULL_LOAD;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift_reg <= {rxs, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        baud_cnt  <= FULL_LOAD;
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        par_bad  <= (rxs != ^shift_reg);
                        state    <= ST_STOP;
                        baud_cnt <= FULL_LOAD;
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        state <= rxs ? ST_IDLE : ST_WAIT_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rxs) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_err <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            frame_err <= frame_set | (frame_err & ~err_clr);
            ovf_err   <= ovf_set   | (ovf_err   & ~err_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    // Sticky parity error flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            par_err <= 1'b0;
        end else begin
            par_err <= par_set | (par_err & ~err_clr);
        end
    end
`else
    assign par_err = 1'b0;
`endif

    assign rx_valid = !fifo_empty;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (shift_reg),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule
